// File: rtl/prbs8_checker.sv
// PRBS8 receive checker: self-synchronises to the x^8+x^6+x^5+x^4+1 Fibonacci stream,
// declares lock, counts bit errors, and shows the low error byte on two 7-segment digits.
module prbs8_checker #(
   parameter int unsigned LOCK_THRESH   = 16,
   parameter int unsigned UNLOCK_THRESH = 4,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             din_valid,
   input  logic             din,
   input  logic             clear_cnt,
   output logic             locked,
   output logic             err_pulse,
   output logic [CNT_W-1:0] err_cnt,
   output logic [7:0]       seg_hi,
   output logic [7:0]       seg_lo
);

   typedef enum logic [1:0] {FILL, VERIFY, LOCKED} state_t;

   state_t           state, state_nxt;
   logic [7:0]       sh, sh_nxt;
   logic [2:0]       fill_cnt, fill_cnt_nxt;
   logic [7:0]       good_cnt, good_cnt_nxt;
   logic [3:0]       bad_cnt, bad_cnt_nxt;
   logic             locked_nxt, err_pulse_nxt;
   logic [CNT_W-1:0] err_cnt_nxt;
   logic             pred, mismatch, good_bit;

   assign pred     = sh[0] ^ sh[2] ^ sh[3] ^ sh[4];
   assign mismatch = din_valid & (din != pred);
   // An all-zero history is the LFSR lock-up state, so it never counts as a good prediction.
   assign good_bit = !mismatch && (sh != 8'd0);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         sh        <= 8'd0;
         fill_cnt  <= 3'd0;
         good_cnt  <= 8'd0;
         bad_cnt   <= 4'd0;
         locked    <= 1'b0;
         err_pulse <= 1'b0;
         err_cnt   <= '0;
      end else begin
         state     <= state_nxt;
         sh        <= sh_nxt;
         fill_cnt  <= fill_cnt_nxt;
         good_cnt  <= good_cnt_nxt;
         bad_cnt   <= bad_cnt_nxt;
         locked    <= locked_nxt;
         err_pulse <= err_pulse_nxt;
         err_cnt   <= err_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      sh_nxt        = sh;
      fill_cnt_nxt  = fill_cnt;
      good_cnt_nxt  = good_cnt;
      bad_cnt_nxt   = bad_cnt;
      locked_nxt    = locked;
      err_pulse_nxt = 1'b0;
      err_cnt_nxt   = err_cnt;
      if (din_valid) begin
         case (state)
            FILL: begin
               sh_nxt       = {din, sh[7:1]};
               fill_cnt_nxt = fill_cnt + 3'd1;
               if (fill_cnt == 3'd7) begin
                  state_nxt    = VERIFY;
                  good_cnt_nxt = 8'd0;
               end
            end
            VERIFY: begin
               sh_nxt       = {din, sh[7:1]};
               good_cnt_nxt = good_bit ? good_cnt + 8'd1 : 8'd0;
               if (good_bit && (good_cnt + 8'd1 == 8'(LOCK_THRESH))) begin
                  state_nxt   = LOCKED;
                  locked_nxt  = 1'b1;
                  bad_cnt_nxt = 4'd0;
               end
            end
            LOCKED: begin
               // Flywheel on the prediction so a received error does not corrupt the history.
               sh_nxt = {pred, sh[7:1]};
               if (mismatch) begin
                  err_pulse_nxt = 1'b1;
                  if (err_cnt != '1) err_cnt_nxt = err_cnt + CNT_W'(1);
                  bad_cnt_nxt = bad_cnt + 4'd1;
                  if (bad_cnt + 4'd1 == 4'(UNLOCK_THRESH)) begin
                     state_nxt    = FILL;
                     fill_cnt_nxt = 3'd0;
                     locked_nxt   = 1'b0;
                  end
               end else begin
                  bad_cnt_nxt = 4'd0;
               end
            end
            default: begin
               state_nxt    = FILL;
               fill_cnt_nxt = 3'd0;
               locked_nxt   = 1'b0;
            end
         endcase
      end
      if (clear_cnt) err_cnt_nxt = '0;
   end

   // Segment order {a,b,c,d,e,f,g,dp}, active low, dp dark.
   function automatic logic [7:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 8'b00000011;
         4'h1: hex7 = 8'b10011111;
         4'h2: hex7 = 8'b00100101;
         4'h3: hex7 = 8'b00001101;
         4'h4: hex7 = 8'b10011001;
         4'h5: hex7 = 8'b01001001;
         4'h6: hex7 = 8'b01000001;
         4'h7: hex7 = 8'b00011111;
         4'h8: hex7 = 8'b00000001;
         4'h9: hex7 = 8'b00001001;
         4'hA: hex7 = 8'b00010001;
         4'hB: hex7 = 8'b11000001;
         4'hC: hex7 = 8'b01100011;
         4'hD: hex7 = 8'b10000101;
         4'hE: hex7 = 8'b01100001;
         default: hex7 = 8'b01110001;
      endcase
   endfunction

   always_comb begin
      seg_hi = hex7(err_cnt[7:4]);
      seg_lo = hex7(err_cnt[3:0]);
   end

endmodule

// File: doc/prbs8_checker.md
Name: prbs8_checker

Overview:
- Receive-side counterpart of the team's 8-bit Fibonacci LFSR pattern generator.
- Takes the generator's serial output bit stream, self-synchronises to it, declares lock, then counts bit errors.
- Displays the low byte of the error count on two active-low 7-segment digits.
- Sits on the board-test path as the PRBS link/loopback checker.

Parameters:
LOCK_THRESH, 16, consecutive correct predictions in VERIFY required to assert locked (1..255)
UNLOCK_THRESH, 4, consecutive mispredictions in LOCKED that drop lock (1..15)
CNT_W, 16, width of the saturating error counter (>=8)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
din_valid  in  1  qualifies din; no state changes when low
din  in  1  received serial bit (generator's q[0], one bit per valid cycle)
clear_cnt  in  1  synchronous clear of err_cnt
locked  out  1  registered; high in LOCKED state
err_pulse  out  1  registered; one-cycle pulse per counted error
err_cnt  out  CNT_W  registered saturating error count
seg_hi  out  8  active-low hex digit of err_cnt[7:4]
seg_lo  out  8  active-low hex digit of err_cnt[3:0]

Behaviour:
- Polynomial: s[n+8] = s[n] ^ s[n+2] ^ s[n+3] ^ s[n+4].
- History register sh[7:0]; on each valid bit b: sh <= {b', sh[7:1]}. sh[0] is the oldest bit.
- Prediction: pred = sh[0]^sh[2]^sh[3]^sh[4]. Mismatch = din_valid & (din != pred).
- Reset values: state FILL, sh = 0, fill_cnt = 0, good_cnt = 0, bad_cnt = 0, locked = 0, err_pulse = 0, err_cnt = 0.
- FILL:
  - Each valid bit shifts in b' = din and increments fill_cnt.
  - No comparison is made.
  - On the 8th valid bit: go to VERIFY, good_cnt = 0.
- VERIFY:
  - b' = din, so the received bit is shifted in.
  - Match with sh != 0: good_cnt++.
  - Mismatch, or sh == 0: good_cnt = 0. The all-zero history is treated as illegal.
  - When good_cnt reaches LOCK_THRESH on a valid bit: go to LOCKED, locked = 1 at that same edge, bad_cnt = 0.
  - Errors are not counted in VERIFY.
- LOCKED:
  - b' = pred, so the generator is flywheeled and a single error does not propagate.
  - Mismatch: err_pulse = 1 for the next cycle only; err_cnt++ (saturates at all-ones); bad_cnt++.
  - Match: bad_cnt = 0.
  - When bad_cnt reaches UNLOCK_THRESH: go to FILL, fill_cnt = 0, locked = 0 at that edge. The error that triggers the drop is still counted.
- err_pulse is 0 in every cycle that has no counted mismatch, including cycles with din_valid = 0.
- clear_cnt:
  - err_cnt = 0 at the next edge.
  - Takes priority over a simultaneous increment; that error is dropped from err_cnt but err_pulse still fires.
  - Does not affect the FSM.
- Latency: decision on a valid bit is visible on locked, err_pulse and err_cnt one edge later.
- Display:
  - Combinational decode of registered err_cnt[7:0].
  - Bit order {a,b,c,d,e,f,g,dp}; 0 = segment lit; dp always off (bit0 = 1).
  - Full hex 0-F set, e.g. 0 = 8'b00000011, 3 = 8'b00001101, A = 8'b00010001, F = 8'b01110001.
- rst mid-operation returns everything to reset values on the next edge, regardless of state.

Test Plan:
1. rst, then a continuous valid generator stream seeded 8'h01 -> locked rises at the edge of the 24th valid bit (8 fill + 16 verify); err_cnt stays 0; seg_hi = seg_lo = 8'b00000011.
2. Locked, flip one bit -> err_pulse high exactly one cycle, err_cnt = 1, locked stays 1; following bits match (flywheel), so no further errors.
3. Locked, flip 4 consecutive bits -> err_cnt += 4, locked falls on the 4th flip's edge; clean stream afterwards -> relock 24 valid bits later.
4. Constant din = 0 for 100 valid bits -> locked never asserts; err_cnt = 0.
5. CNT_W = 8, lock, inject 300 isolated errors -> err_cnt = 8'hFF and holds; clear_cnt coincident with an error -> err_cnt = 0, err_pulse = 1.
6. Force err_cnt to 8'h3A via errors -> seg_hi = 8'b00001101, seg_lo = 8'b00010001; din_valid gaps mid-stream -> no state, count or pulse changes during gaps.
